sha256_msg_sched: RTL and testbench

//  Message-schedule stage directly upstream of the SHA-256 round core.
//  - Accepts one 512-bit block over a valid/ready handshake.
//  - Emits W[t] and K[t] once per cycle for t=0..ROUNDS-1 to drive the core's Wt/Kt inputs.
//  - Uses a 16-word sliding window plus the internal 64-entry K-constant ROM.

---
 rtl/sha256_msg_sched.sv | 152 +++++++++++++++
 tb/tb_sha256_msg_sched.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// rtl/sha256_msg_sched.sv - SHA-256 message schedule: streams W[t]/K[t] per round
//
// Takes one 512-bit block over a valid/ready handshake and emits the schedule
// word W[t] and round constant K[t] once per cycle for t = 0..ROUNDS-1.
// A 16-word sliding window produces W[16..] on the fly.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   blk_valid/ready   block handshake; blk_data word 0 in [511:480]
//   hold              freezes all state and outputs, blocks acceptance
//   wt_valid          Wt/Kt/t_idx/first/last valid this cycle
//   Wt, Kt            schedule word and round constant
//   t_idx             round index of the current output
//   first, last       wt_valid at t_idx==0 / t_idx==ROUNDS-1
//
// Build option: define SHA256_SCHED_BSWAP_EN to byte-reverse every input word
// on load (little-endian source). Latency and handshake are unchanged.

module sha256_msg_sched #(
  parameter int ROUNDS = 64,
  parameter int T_W    = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           blk_valid,
  output logic           blk_ready,
  input  logic [511:0]   blk_data,
  input  logic           hold,
  output logic           wt_valid,
  output logic [31:0]    Wt,
  output logic [31:0]    Kt,
  output logic [T_W-1:0] t_idx,
  output logic           first,
  output logic           last
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [T_W-1:0] LAST_T = T_W'(ROUNDS - 1);

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] load_word(input logic [31:0] x);
`ifdef SHA256_SCHED_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  state_t         state_q, state_d;
  logic [31:0]    w_q [16];
  logic [31:0]    src [16];
  logic [31:0]    w_d [16];
  logic           accept, step, done;
  logic [T_W-1:0] t_inc;
  logic [5:0]     rom_idx;

  always_comb begin
    blk_ready = !hold && (state_q == S_IDLE || (state_q == S_RUN && t_idx == LAST_T));
    accept    = blk_valid && blk_ready;
    step      = !hold && state_q == S_RUN && t_idx != LAST_T;
    done      = !hold && state_q == S_RUN && t_idx == LAST_T && !accept;
    t_inc     = t_idx + 1'b1;
    rom_idx   = 6'(t_inc);

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (done)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The accept edge and a RUN step share one datapath: the source window
    // is either the freshly loaded block or the current window. Its word 0
    // goes out, and the window shifts with the next schedule word appended.
    for (int i = 0; i < 16; i++) begin
      src[i] = accept ? load_word(blk_data[511 - 32*i -: 32]) : w_q[i];
    end
    for (int i = 0; i < 15; i++) begin
      w_d[i] = src[i+1];
    end
    w_d[15] = sigma1(src[14]) + src[9] + sigma0(src[1]) + src[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wt_valid <= 1'b0;
      Wt       <= '0;
      Kt       <= '0;
      t_idx    <= '0;
      first    <= 1'b0;
      last     <= 1'b0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else if (accept) begin
      wt_valid <= 1'b1;
      Wt       <= src[0];
      Kt       <= K_ROM[0];
      t_idx    <= '0;
      first    <= 1'b1;
      last     <= 1'b0;
      for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
    end else if (step) begin
      Wt       <= src[0];
      Kt       <= K_ROM[rom_idx];
      t_idx    <= t_inc;
      first    <= 1'b0;
      last     <= (t_inc == LAST_T);
      for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
    end else if (done) begin
      // Wt/Kt/t_idx deliberately keep the last round's values.
      wt_valid <= 1'b0;
      first    <= 1'b0;
      last     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb/tb_sha256_msg_sched.sv - self-checking bench for sha256_msg_sched
module tb_sha256_msg_sched;

  localparam int ROUNDS = 64;
  localparam int T_W    = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           blk_valid;
  logic           blk_ready;
  logic [511:0]   blk_data;
  logic           hold;
  logic           wt_valid;
  logic [31:0]    Wt;
  logic [31:0]    Kt;
  logic [T_W-1:0] t_idx;
  logic           first;
  logic           last;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [T_W-1:0] t;
    logic [31:0]    w;
    logic [31:0]    k;
    logic           f;
    logic           l;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [31:0] KTAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_msg_sched #(.ROUNDS(ROUNDS), .T_W(T_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .hold      (hold),
    .wt_valid  (wt_valid),
    .Wt        (Wt),
    .Kt        (Kt),
    .t_idx     (t_idx),
    .first     (first),
    .last      (last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] x);
`ifdef SHA256_SCHED_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic push_block(input logic [511:0] d);
    logic [31:0] w [64];
    exp_t e;
    for (int i = 0; i < 16; i++) w[i] = m_load(d[511 - 32*i -: 32]);
    for (int i = 16; i < 64; i++) w[i] = m_s1(w[i-2]) + w[i-7] + m_s0(w[i-15]) + w[i-16];
    for (int t = 0; t < ROUNDS; t++) begin
      e.t = T_W'(t);
      e.w = w[t];
      e.k = KTAB[t];
      e.f = (t == 0);
      e.l = (t == ROUNDS - 1);
      sb_q.push_back(e);
    end
  endtask

  // One clock: record an accept into the scoreboard, consume the current
  // output word if the consumer is not stalled, then advance to edge+1.
  task automatic cycle(output bit acc);
    exp_t e;
    #1;
    acc = blk_valid && blk_ready;
    if (acc) push_block(blk_data);
    if (wt_valid && !hold) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: wt_valid=1 t_idx=%0d but no word expected", t_idx);
      end else begin
        e = sb_q.pop_front();
        if (t_idx !== e.t || Wt !== e.w || Kt !== e.k || first !== e.f || last !== e.l) begin
          errors++;
          $display("FAIL sb_word: got t=%0d W=%h K=%h f=%b l=%b, want t=%0d W=%h K=%h f=%b l=%b",
                   t_idx, Wt, Kt, first, last, e.t, e.w, e.k, e.f, e.l);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    for (int n = 0; n < ROUNDS + 10; n++) begin
      if (!wt_valid) break;
      cycle(acc);
    end
    checks++;
    if (wt_valid !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: wt_valid=%b pending=%0d, want 0 and 0", wt_valid, sb_q.size());
    end
  endtask

  task automatic start_block(input logic [511:0] d);
    bit acc;
    blk_data  = d;
    blk_valid = 1'b1;
    cycle(acc);
    blk_valid = 1'b0;
    checks++;
    if (acc !== 1'b1) begin
      errors++;
      $display("FAIL start_accept: accepted=%b, want 1", acc);
    end
  endtask

  task automatic run_to(input int t);
    bit acc;
    for (int n = 0; n < ROUNDS && t_idx != T_W'(t); n++) cycle(acc);
    checks++;
    if (t_idx !== T_W'(t) || wt_valid !== 1'b1) begin
      errors++;
      $display("FAIL run_to: t_idx=%0d wt_valid=%b, want %0d and 1", t_idx, wt_valid, t);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (wt_valid !== 0 || Wt !== 0 || Kt !== 0 || t_idx !== 0 || first !== 0 || last !== 0) begin
      errors++;
      $display("FAIL reset_outputs: v=%b W=%h K=%h t=%0d f=%b l=%b, want all 0",
               wt_valid, Wt, Kt, t_idx, first, last);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (blk_ready !== 1'b1 || wt_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: blk_ready=%b wt_valid=%b, want 1 and 0", blk_ready, wt_valid);
    end
  endtask

  task automatic test_abc();
    logic [511:0] abc;
    bit acc;
    abc = '0;
`ifdef SHA256_SCHED_BSWAP_EN
    abc[511:480] = 32'h80636261;
    abc[31:0]    = 32'h18000000;
`else
    abc[511:480] = 32'h61626380;
    abc[31:0]    = 32'h00000018;
`endif
    start_block(abc);
    checks++;
    if (wt_valid !== 1 || t_idx !== 0 || Wt !== 32'h61626380 || Kt !== 32'h428a2f98 || first !== 1) begin
      errors++;
      $display("FAIL abc_t0: v=%b t=%0d W=%h K=%h f=%b, want 1 0 61626380 428a2f98 1",
               wt_valid, t_idx, Wt, Kt, first);
    end
    for (int n = 1; n < ROUNDS; n++) begin
      cycle(acc);
      if (n == 16) begin
        checks++;
        if (t_idx !== 16 || Wt !== 32'h61626380 || Kt !== 32'he49b69c1) begin
          errors++;
          $display("FAIL abc_t16: t=%0d W=%h K=%h, want 16 61626380 e49b69c1", t_idx, Wt, Kt);
        end
      end
      if (n == 17) begin
        checks++;
        if (t_idx !== 17 || Wt !== 32'h000f0000) begin
          errors++;
          $display("FAIL abc_t17: t=%0d W=%h, want 17 000f0000", t_idx, Wt);
        end
      end
      if (n == 63) begin
        checks++;
        if (t_idx !== 63 || Kt !== 32'hc67178f2 || last !== 1 || first !== 0) begin
          errors++;
          $display("FAIL abc_t63: t=%0d K=%h l=%b f=%b, want 63 c67178f2 1 0", t_idx, Kt, last, first);
        end
      end
    end
    cycle(acc);
    checks++;
    if (wt_valid !== 0 || t_idx !== 63 || Kt !== 32'hc67178f2 || last !== 0) begin
      errors++;
      $display("FAIL abc_after: v=%b t=%0d K=%h l=%b, want 0 63 c67178f2 0", wt_valid, t_idx, Kt, last);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL abc_pending: %0d words left, want 0", sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] b;
    logic [T_W-1:0] tb;
    bit acc, seen;
    int gaps;
    b = rand_block();
    start_block(rand_block());
    blk_data  = b;
    blk_valid = 1'b1;
    seen = 0;
    gaps = 0;
    for (int n = 0; n < ROUNDS + 10 && !seen; n++) begin
      tb = t_idx;
      cycle(acc);
      if (!wt_valid) gaps++;
      if (acc) begin
        seen = 1;
        blk_valid = 1'b0;
        checks++;
        if (tb !== 63) begin
          errors++;
          $display("FAIL b2b_accept_t: accepted at t=%0d, want 63", tb);
        end
        checks++;
        if (wt_valid !== 1 || t_idx !== 0 || first !== 1 || Wt !== m_load(b[511:480])) begin
          errors++;
          $display("FAIL b2b_next: v=%b t=%0d f=%b W=%h, want 1 0 1 %h",
                   wt_valid, t_idx, first, Wt, m_load(b[511:480]));
        end
      end
    end
    blk_valid = 1'b0;
    checks++;
    if (!seen || gaps != 0) begin
      errors++;
      $display("FAIL b2b_gap: accepted=%b gaps=%0d, want 1 and 0", seen, gaps);
    end
    drain();
  endtask

  task automatic test_hold();
    logic [31:0] ws, ks;
    bit acc;
    start_block(rand_block());
    run_to(20);
    ws = Wt;
    ks = Kt;
    hold = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cycle(acc);
      checks++;
      if (t_idx !== 20 || Wt !== ws || Kt !== ks || wt_valid !== 1 || blk_ready !== 0) begin
        errors++;
        $display("FAIL hold_freeze: t=%0d W=%h K=%h v=%b rdy=%b, want 20 %h %h 1 0",
                 t_idx, Wt, Kt, wt_valid, blk_ready, ws, ks);
      end
    end
    hold = 1'b0;
    cycle(acc);
    checks++;
    if (t_idx !== 21 || wt_valid !== 1) begin
      errors++;
      $display("FAIL hold_resume: t=%0d v=%b, want 21 1", t_idx, wt_valid);
    end
    drain();
  endtask

  task automatic test_ignore();
    logic [T_W-1:0] tb;
    bit acc, seen;
    start_block(rand_block());
    run_to(10);
    blk_data  = rand_block();
    blk_valid = 1'b1;
    seen = 0;
    for (int n = 0; n < ROUNDS + 10 && !seen; n++) begin
      tb = t_idx;
      cycle(acc);
      if (acc) begin
        seen = 1;
        blk_valid = 1'b0;
        checks++;
        if (tb !== 63) begin
          errors++;
          $display("FAIL ign_accept_t: accepted at t=%0d, want 63", tb);
        end
      end else if (t_idx != 63) begin
        checks++;
        if (blk_ready !== 1'b0) begin
          errors++;
          $display("FAIL ign_ready: blk_ready=%b at t=%0d, want 0", blk_ready, t_idx);
        end
      end
    end
    blk_valid = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ign_never: accepted=0, want 1");
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bit acc;
    start_block(rand_block());
    for (int n = 0; n < 30; n++) cycle(acc);
    rst_n = 1'b0;
    #1;
    checks++;
    if (wt_valid !== 0 || Wt !== 0 || Kt !== 0 || t_idx !== 0 || first !== 0 || last !== 0) begin
      errors++;
      $display("FAIL rst_async: v=%b W=%h K=%h t=%0d f=%b l=%b, want all 0",
               wt_valid, Wt, Kt, t_idx, first, last);
    end
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (blk_ready !== 1 || wt_valid !== 0) begin
      errors++;
      $display("FAIL rst_release: blk_ready=%b wt_valid=%b, want 1 0", blk_ready, wt_valid);
    end
    for (int n = 0; n < 4; n++) begin
      cycle(acc);
      checks++;
      if (wt_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_quiet: wt_valid=%b, want 0", wt_valid);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    blk_valid = 1'b0;
    blk_data  = '0;
    hold      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_abc();
    test_back_to_back();
    test_hold();
    test_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
